// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants, address-phase FSM states and the command record
// used by ahb_cfg_master and its command FIFO.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_BUSY     = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [1:0] HTRANS_SEQ      = 2'b11;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ERR2
  } ahb_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb_cfg_master_if.sv
// Command stream plus AHB-Lite bus of ahb_cfg_master; master = the initiator,
// slave = the command source and the AHB target together.
interface ahb_cfg_master_if;

  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [1:0]  o_htrans;
  logic        o_hselx;
  logic        o_hwrite;
  logic [31:0] o_haddr;
  logic [31:0] o_hwdata;
  logic [2:0]  o_hsize;
  logic [2:0]  o_hburst;
  logic [3:0]  o_hprot;
  logic        o_hmastlock;
  logic        o_hready;
  logic        i_hreadyout;
  logic        i_hresp;
  logic [31:0] i_hrdata;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    input  i_hreadyout, i_hresp, i_hrdata,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_htrans, o_hselx, o_hwrite, o_haddr, o_hwdata,
    output o_hsize, o_hburst, o_hprot, o_hmastlock, o_hready
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    output i_hreadyout, i_hresp, i_hrdata,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_htrans, o_hselx, o_hwrite, o_haddr, o_hwdata,
    input  o_hsize, o_hburst, o_hprot, o_hmastlock, o_hready
  );

endinterface

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a counter.
module ahb_cmd_fifo
  import ahb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push,
  input  ahb_cmd_t wr_cmd,
  input  logic     pop,
  output ahb_cmd_t rd_cmd,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  ahb_cmd_t        mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rd_cmd  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_cmd;
  end

endmodule

// File: rtl/ahb_cfg_master.sv
// AHB-Lite single-transfer initiator fed from a command FIFO; address phase of
// the FIFO head overlaps the data phase of the previous transfer.
// Optional wait-state timeout is enabled by defining AHB_MST_TIMEOUT_EN.
module ahb_cfg_master
  import ahb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              i_clk_ahb,
  input logic              i_rstn_ahb,
  ahb_cfg_master_if.master bus
);

  ahb_cmd_t   wr_cmd;
  ahb_cmd_t   head;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  ahb_state_e state;
  ahb_state_e state_nxt;
  logic       issue;
  logic       keep;
  logic       err_first;
  logic       dp_done;
  logic       tmo_hit;
  logic       dp_valid;
  logic       dp_write;
  logic [31:0] dp_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  assign wr_cmd = '{write: bus.i_cmd_write, addr: bus.i_cmd_addr, wdata: bus.i_cmd_wdata};
  assign push   = bus.i_cmd_valid & ~full;
  assign pop    = issue & bus.i_hreadyout;

  ahb_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (i_clk_ahb),
    .rstn   (i_rstn_ahb),
    .push   (push),
    .wr_cmd (wr_cmd),
    .pop    (pop),
    .rd_cmd (head),
    .full   (full),
    .empty  (empty)
  );

  assign err_first = dp_valid & bus.i_hresp & ~bus.i_hreadyout;
  assign dp_done   = dp_valid & bus.i_hreadyout;

`ifdef AHB_MST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             stalled;

  assign stalled = dp_valid & ~bus.i_hreadyout;
  assign tmo_hit = stalled & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb || !stalled || tmo_hit) tmo_cnt <= '0;
    else                                    tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Head is issued combinationally so the first cycle of an ERROR (or a
  // timeout) can drop HTRANS to IDLE in that same cycle.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    keep      = 1'b0;
    case (state)
      ST_IDLE, ST_ACTIVE: begin
        issue = ~empty & ~err_first & ~tmo_hit;
        keep  = ~empty | push | issue | (dp_valid & ~dp_done & ~tmo_hit);
        if (err_first && !tmo_hit) state_nxt = ST_ERR2;
        else                       state_nxt = keep ? ST_ACTIVE : ST_IDLE;
      end
      ST_ERR2: begin
        keep = ~empty | push;
        if (bus.i_hreadyout || tmo_hit) state_nxt = keep ? ST_ACTIVE : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (pop) begin
      dp_valid <= 1'b1;
      dp_write <= head.write;
      dp_wdata <= head.wdata;
    end else if (dp_done || tmo_hit) begin
      dp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dp_done | tmo_hit;
      rsp_err   <= tmo_hit | (dp_done & bus.i_hresp);
      rsp_rdata <= (dp_done && !dp_write) ? bus.i_hrdata : '0;
    end
  end

  assign bus.o_cmd_ready = ~full;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_err   = rsp_err;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.o_hselx     = issue;
  assign bus.o_hwrite    = issue & head.write;
  assign bus.o_haddr     = issue ? (head.addr & ~32'h3) : '0;
  assign bus.o_hwdata    = dp_wdata;
  assign bus.o_hsize     = HSIZE_WORD;
  assign bus.o_hburst    = HBURST_SINGLE;
  assign bus.o_hprot     = HPROT_DATA_PRIV;
  assign bus.o_hmastlock = 1'b0;
  assign bus.o_hready    = bus.i_hreadyout;

endmodule
